// File: rtl/trng_postproc.sv
// TRNG entropy conditioning: raw-bit synchroniser, repetition-count health test,
// von Neumann debiasing and byte packing onto a valid/ready output.
module trng_postproc #(
  parameter int REP_LIMIT   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       raw_bit,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       health_fail
);

  localparam logic [7:0] REP_MAX = 8'(REP_LIMIT);

  typedef enum logic {FIRST, SECOND} pair_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [7:0]             rep_cnt_q, rep_cnt_d;
  logic                   prev_q, prev_d;
  logic                   prev_vld_q, prev_vld_d;
  pair_e                  pair_q, pair_d;
  logic                   a_q, a_d;
  logic [7:0]             shift_q, shift_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             byte_out_q, byte_out_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   health_fail_q, health_fail_d;

  logic s_bit, emit, xfer, out_free;

  assign s_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], raw_bit};
    rep_cnt_d     = rep_cnt_q;
    prev_d        = prev_q;
    prev_vld_d    = prev_vld_q;
    pair_d        = pair_q;
    a_d           = a_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    byte_out_d    = byte_out_q;
    byte_valid_d  = byte_valid_q;
    health_fail_d = health_fail_q;
    emit          = 1'b0;

    if (ena) begin
      if (!prev_vld_q || s_bit != prev_q) rep_cnt_d = 8'd1;
      else if (rep_cnt_q != REP_MAX)      rep_cnt_d = rep_cnt_q + 8'd1;
      prev_d     = s_bit;
      prev_vld_d = 1'b1;
      if (rep_cnt_d == REP_MAX) health_fail_d = 1'b1;

      if (!health_fail_q) begin
        case (pair_q)
          FIRST: begin
            a_d    = s_bit;
            pair_d = SECOND;
          end
          SECOND: begin
            emit   = a_q ^ s_bit;
            pair_d = FIRST;
          end
          default: pair_d = FIRST;
        endcase
      end
    end

    // Output register drains independently of ena.
    xfer     = byte_valid_q && byte_ready;
    out_free = !byte_valid_q || byte_ready;
    if (xfer) byte_valid_d = 1'b0;
    if (bit_cnt_q == 4'd8 && out_free) begin
      byte_out_d   = shift_q;
      byte_valid_d = 1'b1;
      bit_cnt_d    = 4'd0;
    end

    // A full, blocked shift register drops further bits; the emitted bit equals a.
    if (emit && bit_cnt_d != 4'd8) begin
      shift_d   = {shift_d[6:0], a_q};
      bit_cnt_d = bit_cnt_d + 4'd1;
    end

    if (health_fail_d) begin
      byte_valid_d = 1'b0;
      shift_d      = 8'h00;
      bit_cnt_d    = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      rep_cnt_q     <= 8'd0;
      prev_q        <= 1'b0;
      prev_vld_q    <= 1'b0;
      pair_q        <= FIRST;
      a_q           <= 1'b0;
      shift_q       <= 8'h00;
      bit_cnt_q     <= 4'd0;
      byte_out_q    <= 8'h00;
      byte_valid_q  <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      rep_cnt_q     <= rep_cnt_d;
      prev_q        <= prev_d;
      prev_vld_q    <= prev_vld_d;
      pair_q        <= pair_d;
      a_q           <= a_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
      health_fail_q <= health_fail_d;
    end
  end

  assign byte_out    = byte_out_q;
  assign byte_valid  = byte_valid_q;
  assign health_fail = health_fail_q;

endmodule

// File: tb/tb_trng_postproc.sv
// Bench for trng_postproc: queue-based reference model compared every cycle,
// plus directed scenarios for bias removal, backpressure, health failure and reset.
module tb_trng_postproc;
  localparam int SYNC = 2;
  localparam int LIM  = 32;

  logic       clk = 0, rst_n = 0, ena = 0, raw_bit = 0, byte_ready = 0;
  logic [7:0] byte_out;
  logic       byte_valid, health_fail;

  always #5 clk = ~clk;

  trng_postproc #(.REP_LIMIT(LIM), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_bit(raw_bit),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .health_fail(health_fail)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: delay line for the synchroniser, run length, pair buffer,
  // and a queue of extracted bits awaiting a byte.
  bit       sq[$];
  bit       pend[$];
  int       run, m_nx;
  bit       prev, have_prev, have_a, a, m_fail, m_valid;
  bit [7:0] m_byte;

  function automatic void m_reset();
    sq = {};
    repeat (SYNC) sq.push_back(1'b0);
    pend = {};
    run = 0; have_prev = 0; prev = 0; have_a = 0; a = 0;
    m_fail = 0; m_valid = 0; m_byte = 8'h00;
  endfunction

  function automatic void m_step(bit e, bit r, bit raw);
    bit s, emit, eb, fail_now, xfer;
    s = sq.pop_front();
    sq.push_back(raw);
    xfer = m_valid && r;
    if (xfer) m_nx++;
    emit = 0; eb = 0; fail_now = 0;
    if (e) begin
      if (have_prev && s == prev) begin
        if (run < LIM) run++;
      end else run = 1;
      prev = s; have_prev = 1;
      if (run == LIM) fail_now = 1;
      if (!m_fail) begin
        if (!have_a) begin a = s; have_a = 1; end
        else begin
          have_a = 0;
          if (a != s) begin emit = 1; eb = a; end
        end
      end
    end
    if (m_fail || fail_now) begin
      m_fail = 1; m_valid = 0; pend = {};
    end else begin
      if (pend.size() == 8 && (!m_valid || r)) begin
        for (int i = 0; i < 8; i++) m_byte[7-i] = pend[i];
        m_valid = 1;
        pend = {};
      end else if (xfer) m_valid = 0;
      if (emit && pend.size() < 8) pend.push_back(eb);
    end
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_reset();
    else        m_step(ena, byte_ready, raw_bit);

  // Per-cycle comparison and transfer log.
  bit       chk_on = 0, vld_seen = 0;
  bit [7:0] xq[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid && byte_ready) xq.push_back(byte_out);
      if (byte_valid) vld_seen = 1;
      if (chk_on) begin
        chk("valid", int'(byte_valid), int'(m_valid));
        chk("fail", int'(health_fail), int'(m_fail));
        if (m_valid) chk("byte", int'(byte_out), int'(m_byte));
      end
    end
  end

  // Stimulus stream: raw bits and the enable that samples each one, applied
  // SYNC cycles later so that sample j sees raw bit j.
  bit rq[$], eq[$];
  function automatic void add(bit r, bit e);
    rq.push_back(r); eq.push_back(e);
  endfunction
  function automatic void pair(bit x, bit y);
    add(x, 1); add(y, 1);
  endfunction

  task automatic play();
    int n = rq.size();
    for (int i = 0; i < n + SYNC + 1; i++) begin
      @(posedge clk); #1;
      raw_bit = (i < n) ? rq[i] : 1'($urandom);
      ena     = (i >= SYNC && i - SYNC < n) ? eq[i-SYNC] : 1'b0;
    end
    rq = {}; eq = {};
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ena = 0; byte_ready = 0; rst_n = 0;
    idle(2);
    rst_n = 1;
    xq = {}; vld_seen = 0;
  endtask

  function automatic bit [7:0] rnd_byte_pairs(int from, int cnt, bit [7:0] acc);
    bit x;
    for (int i = from; i < from + cnt; i++) begin
      x = 1'($urandom);
      pair(x, !x);
      acc = {acc[6:0], x};
    end
    return acc;
  endfunction

  bit [7:0] expb;

  initial begin
    m_reset();
    do_reset();
    chk("rst_byte", int'(byte_out), 0);
    chk("rst_valid", int'(byte_valid), 0);
    chk("rst_fail", int'(health_fail), 0);
    chk_on = 1;

    // Known pairs give 0xA5.
    byte_ready = 1;
    pair(1,0); pair(0,1); pair(1,0); pair(0,1);
    pair(0,1); pair(1,0); pair(0,1); pair(1,0);
    play(); idle(4);
    chk("t1_nxfer", xq.size(), 1);
    chk("t1_byte", xq.size() > 0 ? int'(xq[0]) : -1, 'hA5);
    chk("t1_fail", int'(health_fail), 0);

    // Equal pairs emit nothing.
    do_reset(); byte_ready = 1;
    repeat (16) begin pair(0,0); pair(1,1); end
    play(); idle(4);
    chk("t2_vld", int'(vld_seen), 0);
    chk("t2_fail", int'(health_fail), 0);

    // Backpressure: 24 bits, one byte held out, one in the shift register.
    do_reset(); byte_ready = 0;
    repeat (24) pair(1,0);
    play(); idle(2);
    chk("t3_valid", int'(byte_valid), 1);
    chk("t3_byte", int'(byte_out), 'hFF);
    chk("t3_noxfer", xq.size(), 0);
    byte_ready = 1;
    idle(6);
    chk("t3_nxfer", xq.size(), 2);
    chk("t3_x0", xq.size() > 0 ? int'(xq[0]) : -1, 'hFF);
    chk("t3_x1", xq.size() > 1 ? int'(xq[1]) : -1, 'hFF);
    chk("t3_idle", int'(byte_valid), 0);

    // Repetition failure with a byte waiting.
    do_reset(); byte_ready = 0;
    repeat (8) pair(1,0);
    repeat (LIM) add(1, 1);
    play(); idle(1);
    chk("t4_fail", int'(health_fail), 1);
    chk("t4_valid", int'(byte_valid), 0);
    byte_ready = 1;
    repeat (20) pair(1,0);
    play(); idle(3);
    chk("t4_nxfer", xq.size(), 0);
    chk("t4_sticky", int'(health_fail), 1);

    // ena low for 10 cycles mid-byte.
    do_reset(); byte_ready = 1;
    expb = rnd_byte_pairs(0, 3, 8'h00);
    repeat (10) add(1'($urandom), 0);
    expb = rnd_byte_pairs(3, 5, expb);
    play(); idle(4);
    chk("t5_nxfer", xq.size(), 1);
    chk("t5_byte", xq.size() > 0 ? int'(xq[0]) : -1, int'(expb));

    // Asynchronous reset with a byte waiting and 5 bits pending.
    do_reset(); byte_ready = 0;
    repeat (8) pair(1,0);
    expb = rnd_byte_pairs(0, 5, 8'h00);
    play(); idle(1);
    chk("t6_pre_valid", int'(byte_valid), 1);
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    chk("t6_byte0", int'(byte_out), 0);
    chk("t6_valid0", int'(byte_valid), 0);
    chk("t6_fail0", int'(health_fail), 0);
    #1 rst_n = 1;
    xq = {};
    byte_ready = 1;
    expb = rnd_byte_pairs(0, 8, 8'h00);
    play(); idle(4);
    chk("t6_nxfer", xq.size(), 1);
    chk("t6_byte", xq.size() > 0 ? int'(xq[0]) : -1, int'(expb));

    // Random soak against the model.
    do_reset();
    m_nx = 0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      raw_bit    = 1'($urandom);
      ena        = ($urandom_range(3) != 0);
      byte_ready = 1'($urandom);
    end
    ena = 0; byte_ready = 1;
    idle(3);
    chk("soak_nxfer", xq.size(), m_nx);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
